// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame length, arbiter state encoding and
// the clocks-per-bit helper used by the tx/rx blocks and the tx arbiter.
package uart_pkg;

  localparam int FRAME_BITS_DEFAULT = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_HOLD   = 2'd2
  } arb_state_e;

  function automatic int calc_bit_cycles(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Requester selection for uart_tx_arbiter: one-hot winner plus any-valid flag.
// Round-robin from ptr_i by default; UART_ARB_FIXED_PRIO_EN selects lowest index.
module rr_select #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req_valid_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] sel_onehot_o,
  output logic [PTR_W-1:0] sel_idx_o,
  output logic             any_valid_o
);

`ifdef UART_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  // Scan from the top so the lowest asserted index is the last to overwrite.
  always_comb begin
    sel_onehot_o = '0;
    sel_idx_o    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        sel_onehot_o    = '0;
        sel_onehot_o[i] = 1'b1;
        sel_idx_o       = PTR_W'(i);
      end
    end
  end
`else
  logic             found;
  int               cand;
  logic [PTR_W-1:0] cand_idx;

  // Visit ptr, ptr+1, ... wrapping at N_REQ; the first valid one wins.
  always_comb begin
    sel_onehot_o = '0;
    sel_idx_o    = '0;
    found        = 1'b0;
    cand         = 0;
    cand_idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      cand_idx = PTR_W'(cand);
      if (!found && req_valid_i[cand_idx]) begin
        found                  = 1'b1;
        sel_onehot_o[cand_idx] = 1'b1;
        sel_idx_o              = cand_idx;
      end
    end
  end
`endif

  assign any_valid_o = |req_valid_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among N_REQ byte producers; after each write it waits one
// frame plus guard time. Define UART_ARB_FIXED_PRIO_EN for fixed priority.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD         = 9600,
  parameter int FRAME_BITS   = FRAME_BITS_DEFAULT,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       wr_en,
  output logic [7:0]                 byte_o,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic [1:0]                 dbg_state
);

  localparam int BIT_CYCLES   = calc_bit_cycles(CLK_FREQ, BAUD);
  localparam int FRAME_CYCLES = BIT_CYCLES * FRAME_BITS + GUARD_CYCLES;
  localparam int CNT_W        = $clog2(FRAME_CYCLES + 1);
  localparam int ID_W         = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

  // Handshake: requester i transfers on a rising edge where req_valid[i] and
  // req_ready[i] are both high; req_ready is one-hot and only ever high in IDLE,
  // and req_data must stay stable while req_valid is high.

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [7:0]       byte_q, byte_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_REQ-1:0] sel_onehot;
  logic [ID_W-1:0]  sel_idx;
  logic             any_valid;
  logic [7:0]       sel_byte;

  rr_select #(
    .N_REQ (N_REQ),
    .PTR_W (ID_W)
  ) u_rr_select (
    .req_valid_i  (req_valid),
    .ptr_i        (ptr_q),
    .sel_onehot_o (sel_onehot),
    .sel_idx_o    (sel_idx),
    .any_valid_o  (any_valid)
  );

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_onehot[i]) begin
        sel_byte = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    byte_d     = byte_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    req_ready  = '0;
    wr_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Gate with rst so nothing looks grantable while reset is held.
        if (rst) begin
          req_ready = sel_onehot;
        end
        if (any_valid) begin
          byte_d     = sel_byte;
          grant_id_d = sel_idx;
`ifdef UART_ARB_FIXED_PRIO_EN
          ptr_d      = '0;
`else
          ptr_d      = (sel_idx == ID_LAST) ? '0 : sel_idx + 1'b1;
`endif
          busy_d     = 1'b1;
          state_d    = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        wr_en   = 1'b1;
        cnt_d   = '0;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // uart_tx has no busy flag, so a full frame plus guard is timed here.
        if (cnt_q == CNT_LAST) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      byte_q     <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      byte_q     <= byte_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign byte_o    = byte_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a short frame (FRAME_CYCLES=104).
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N_REQ        = 4;
  localparam int CLK_FREQ     = 1000;
  localparam int BAUD         = 100;
  localparam int FRAME_BITS   = 10;
  localparam int GUARD_CYCLES = 4;
  localparam int FC           = (CLK_FREQ / BAUD) * FRAME_BITS + GUARD_CYCLES;
  localparam int IDLE_GAP     = 1000000;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [N_REQ-1:0]   req_valid = '0;
  logic [8*N_REQ-1:0] req_data = '0;
  logic [N_REQ-1:0]   req_ready;
  logic               wr_en;
  logic [7:0]         byte_o;
  logic               busy;
  logic [1:0]         grant_id;
  logic [1:0]         dbg_state;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ        (N_REQ),
    .CLK_FREQ     (CLK_FREQ),
    .BAUD         (BAUD),
    .FRAME_BITS   (FRAME_BITS),
    .GUARD_CYCLES (GUARD_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .byte_o    (byte_o),
    .busy      (busy),
    .grant_id  (grant_id),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Model: cycles elapsed since the last grant edge, the rotation pointer and
  // the last granted byte/id. Idle means more than FC edges since the grant.
  int         m_gone = IDLE_GAP;
  int         m_ptr  = 0;
  logic [7:0] m_byte = '0;
  int         m_gid  = 0;
  int         m_sel;
  logic [7:0] exp_q[$];
  int         wr_cyc[$];
  logic [7:0] wr_byte[$];

  function automatic int pick(input logic [N_REQ-1:0] v, input int p);
    int r;
    r = -1;
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int i = N_REQ - 1; i >= 0; i--) if (v[i]) r = i;
`else
    for (int k = N_REQ - 1; k >= 0; k--) if (v[(p + k) % N_REQ]) r = (p + k) % N_REQ;
`endif
    return r;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      m_gone = IDLE_GAP;
      m_ptr  = 0;
      m_byte = '0;
      m_gid  = 0;
      exp_q.delete();
    end else begin
      m_sel = pick(req_valid, m_ptr);
      if (m_gone > FC && m_sel >= 0) begin
        m_byte = req_data[8*m_sel +: 8];
        m_gid  = m_sel;
        m_ptr  = (m_sel + 1) % N_REQ;
        m_gone = 0;
        exp_q.push_back(m_byte);
      end else if (m_gone < IDLE_GAP) begin
        m_gone++;
      end
    end
  end

  logic [N_REQ-1:0] e_ready;
  logic             e_wr, e_busy;
  logic [7:0]       e_byte;
  logic [1:0]       e_gid, e_state;
  int               c_sel;

  always @(negedge clk) begin
    if (cmp_en) begin
      e_ready = '0;
      if (!rst) begin
        e_wr = 1'b0; e_busy = 1'b0; e_byte = '0; e_gid = '0; e_state = ST_IDLE;
      end else begin
        e_wr    = (m_gone == 0);
        e_busy  = (m_gone <= FC);
        e_byte  = m_byte;
        e_gid   = 2'(m_gid);
        e_state = (m_gone == 0) ? ST_LAUNCH : ((m_gone <= FC) ? ST_HOLD : ST_IDLE);
        c_sel   = pick(req_valid, m_ptr);
        if (m_gone > FC && c_sel >= 0) e_ready[c_sel] = 1'b1;
      end
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("wr_en", 32'(wr_en), 32'(e_wr));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("byte", 32'(byte_o), 32'(e_byte));
      chk("grant_id", 32'(grant_id), 32'(e_gid));
      chk("state", 32'(dbg_state), 32'(e_state));
      if (wr_en) begin
        wr_cyc.push_back(cyc);
        wr_byte.push_back(byte_o);
        chk("sb_wr_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("sb_byte", 32'(byte_o), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(input int budget, input logic [N_REQ-1:0] exp, input string name);
    int b;
    b = 0;
    @(negedge clk); #1;
    while (req_ready == '0 && b < budget) begin
      @(negedge clk); #1;
      b++;
    end
    chk(name, 32'(req_ready), 32'(exp));
  endtask

  task automatic wait_wr(input int target, input int budget, input string name);
    int b;
    b = 0;
    while (wr_cyc.size() < target && b < budget) begin
      @(negedge clk); #1;
      b++;
    end
    chk(name, 32'(wr_cyc.size()), 32'(target));
  endtask

  task automatic wait_idle(input int budget);
    int b;
    b = 0;
    while (busy && b < budget) begin
      @(negedge clk); #1;
      b++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  logic [7:0] rr_exp[5];

  initial begin
    int n, base, c0, c1, c2;
    @(posedge clk); #2;
    cmp_en = 1'b1;
    @(negedge clk); #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_byte", 32'(byte_o), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);

    // All four continuously valid: rotation and pulse spacing FC+2 = 106.
    tick(1);
    rst = 1'b1;
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'b1111;
    base = wr_cyc.size();
    wait_wr(base + 5, 5 * 106 + 20, "rr_count");
`ifdef UART_ARB_FIXED_PRIO_EN
    rr_exp = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11};
`else
    rr_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
`endif
    for (int k = 0; k < 5; k++) begin
      if (base + k < wr_cyc.size()) chk("rr_byte", 32'(wr_byte[base+k]), 32'(rr_exp[k]));
      if (k > 0 && base + k < wr_cyc.size())
        chk("rr_spacing", 32'(wr_cyc[base+k] - wr_cyc[base+k-1]), 32'd106);
    end
    tick(1);
    req_valid = '0;
    wait_idle(300);

    // Single request from requester 2.
    tick(1);
    req_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
    req_valid = 4'b0100;
    wait_ready(10, 4'b0100, "single_ready");
    tick(1);
    req_valid = '0;
    @(negedge clk); #1;
    chk("single_wr", 32'(wr_en), 32'd1);
    chk("single_byte", 32'(byte_o), 32'hA5);
    chk("single_gid", 32'(grant_id), 32'd2);
    n = 0;
    while (busy && n < 300) begin
      n++;
      @(negedge clk); #1;
    end
    chk("single_busy_len", 32'(n), 32'd105);

    // Requester 1 raises valid in the middle of the hold period.
    tick(1);
    c0 = wr_cyc.size();
    req_data  = {8'h00, 8'h00, 8'h66, 8'h5A};
    req_valid = 4'b0001;
    wait_ready(10, 4'b0001, "hold_first_ready");
    tick(1);
    req_valid = '0;
    tick(20);
    req_valid = 4'b0010;
    @(negedge clk); #1;
    chk("hold_ready_low", 32'(req_ready), 32'd0);
    wait_ready(200, 4'b0010, "hold_ready_grant");
    tick(1);
    req_valid = '0;
    @(negedge clk); #1;
    chk("hold_wr", 32'(wr_en), 32'd1);
    chk("hold_byte", 32'(byte_o), 32'h66);
    chk("hold_count", 32'(wr_cyc.size()), 32'(c0 + 2));
    if (wr_cyc.size() >= 2) chk("hold_spacing", 32'(wr_cyc[$] - wr_cyc[$-1]), 32'd106);

    // Requester 3 valid for a single cycle while busy: must be dropped.
    c1 = wr_cyc.size();
    tick(10);
    req_data  = {8'h77, 8'h00, 8'h00, 8'h00};
    req_valid = 4'b1000;
    tick(1);
    req_valid = '0;
    wait_idle(300);
    tick(10);
    chk("drop_no_wr", 32'(wr_cyc.size()), 32'(c1));
    chk("drop_gid", 32'(grant_id), 32'd1);

    // Reset in the middle of a hold period.
    req_data  = {8'h00, 8'hC3, 8'h00, 8'h00};
    req_valid = 4'b0100;
    wait_ready(10, 4'b0100, "mid_ready");
    tick(1);
    req_valid = '0;
    tick(30);
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst       = 1'b0;
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'b1111;
    #1;
    chk("mid_rst_wr", 32'(wr_en), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_byte", 32'(byte_o), 32'd0);
    tick(3);
    rst = 1'b1;
    c2 = wr_cyc.size();
    wait_wr(c2 + 1, 20, "mid_regrant");
    chk("mid_regrant_byte", 32'(byte_o), 32'h11);
    chk("mid_regrant_gid", 32'(grant_id), 32'd0);
    tick(1);
    req_valid = '0;
    wait_idle(300);
    tick(5);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
